// File: rtl/i_bus_arbiter_n.sv
// Round-robin arbiter multiplexing NCORES instruction-fetch ports onto one memory instruction port.
// Define IBUS_ARB_STATS_EN to add per-core saturating completed-fetch counters on grant_cnt.
module i_bus_arbiter_n #(
    parameter int NCORES = 2,
    parameter int AW     = 32,
    parameter int CNTW   = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NCORES-1:0]      iREN,
    input  logic [NCORES*AW-1:0]   iaddr,
    output logic [NCORES-1:0]      iwait,
    output logic [NCORES*AW-1:0]   iload,
    output logic                   ram_iREN,
    output logic [AW-1:0]          ram_iaddr,
    input  logic [AW-1:0]          ram_iload,
    input  logic                   ram_iwait
`ifdef IBUS_ARB_STATS_EN
    ,
    output logic [NCORES*CNTW-1:0] grant_cnt
`endif
);
    localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gnt_q, gnt_d;
    logic [AW-1:0] addr_q, addr_d;

    logic [AW-1:0] addr_a [NCORES];
    logic [PW-1:0] rr_sel;
    logic [PW-1:0] idx;
    logic          any_req;
    logic          abort;
    logic          complete;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        if (v == PW'(NCORES - 1)) return '0;
        return v + PW'(1);
    endfunction

    for (genvar g = 0; g < NCORES; g++) begin : g_core
        assign addr_a[g]          = iaddr[g*AW +: AW];
        assign iwait[g]           = iREN[g] & ~(complete & (gnt_q == PW'(g)));
        assign iload[g*AW +: AW]  = ram_iload;
    end

    // Scan from ptr upward; iterating downward lets the closest requester win.
    always_comb begin
        any_req = 1'b0;
        rr_sel  = ptr_q;
        idx     = '0;
        for (int k = NCORES - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr_q) + k) % NCORES);
            if (iREN[idx]) begin
                any_req = 1'b1;
                rr_sel  = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        addr_d   = addr_q;
        abort    = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d   = rr_sel;
                    addr_d  = addr_a[rr_sel];
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A withdrawn or redirected fetch beats a same-cycle memory response.
                if (!iREN[gnt_q] || (addr_a[gnt_q] != addr_q)) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (!ram_iwait) begin
                    complete = 1'b1;
                    ptr_d    = wrap_inc(gnt_q);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
        end
    end

    assign ram_iREN  = (state_q == BUSY);
    assign ram_iaddr = addr_q;

`ifdef IBUS_ARB_STATS_EN
    logic [CNTW-1:0] cnt_q [NCORES];
    logic [CNTW-1:0] cnt_d [NCORES];

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < NCORES; i++) begin
            cnt_d[i] = (complete && (gnt_q == PW'(i))) ? sat_inc(cnt_q[i]) : cnt_q[i];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NCORES; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NCORES; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    for (genvar g = 0; g < NCORES; g++) begin : g_cnt
        assign grant_cnt[g*CNTW +: CNTW] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_i_bus_arbiter_n.sv
// Scoreboard bench for i_bus_arbiter_n with four cores; expected fetch completions are queued as stimulus is driven.
`timescale 1ns/1ps
module tb_i_bus_arbiter_n;
    localparam int NC = 4;
    localparam int AW = 32;
    localparam int CW = 2;

    logic            CLK = 1'b0;
    logic            RST;
    logic [NC-1:0]   iREN;
    logic [NC*AW-1:0] iaddr;
    logic [NC-1:0]   iwait;
    logic [NC*AW-1:0] iload;
    logic            ram_iREN;
    logic [AW-1:0]   ram_iaddr;
    logic [AW-1:0]   ram_iload;
    logic [AW-1:0]   ram_iload_drv;
    logic            ram_iwait;
    logic            use_model;
`ifdef IBUS_ARB_STATS_EN
    logic [NC*CW-1:0] grant_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct { int core; logic [AW-1:0] data; } exp_t;
    exp_t sb[$];

    i_bus_arbiter_n #(.NCORES(NC), .AW(AW), .CNTW(CW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iwait     (iwait),
        .iload     (iload),
        .ram_iREN  (ram_iREN),
        .ram_iaddr (ram_iaddr),
        .ram_iload (ram_iload),
        .ram_iwait (ram_iwait)
`ifdef IBUS_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [AW-1:0] mem_f(input logic [AW-1:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign ram_iload = use_model ? mem_f(ram_iaddr) : ram_iload_drv;

    task automatic set_addr(input int c, input logic [AW-1:0] a);
        iaddr[c*AW +: AW] = a;
    endtask

    task automatic push_exp(input int c, input logic [AW-1:0] d);
        exp_t e;
        e.core = c;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() == 0) begin
            e.core = -2;
            e.data = '0;
        end else begin
            e = sb.pop_front();
        end
    endtask

    // Monitor: samples on falling edges until some requesting core sees iwait low.
    task automatic wait_cpl(input int maxc, output int core, output logic [AW-1:0] data, output int cyc);
        core = -1;
        data = '0;
        cyc  = 0;
        while (core < 0 && cyc < maxc) begin
            @(negedge CLK);
            cyc++;
            for (int i = 0; i < NC; i++) begin
                if (iREN[i] && !iwait[i]) begin
                    core = i;
                    data = iload[i*AW +: AW];
                end
            end
        end
    endtask

    task automatic wait_busy(input int maxc, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < maxc) begin
            @(negedge CLK);
            n++;
            if (ram_iREN === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        RST  = 1'b1;
        iREN = 4'b1010;
        repeat (2) @(negedge CLK);
        checks++;
        if (ram_iREN !== 1'b0) begin
            failures++;
            $display("FAIL reset_ram_iREN got=%b want=0", ram_iREN);
        end
        checks++;
        if (ram_iaddr !== 32'h0) begin
            failures++;
            $display("FAIL reset_ram_iaddr got=%h want=0", ram_iaddr);
        end
        checks++;
        if (iwait !== 4'b1010) begin
            failures++;
            $display("FAIL reset_iwait got=%b want=1010", iwait);
        end
`ifdef IBUS_ARB_STATS_EN
        checks++;
        if (grant_cnt !== 8'h00) begin
            failures++;
            $display("FAIL reset_grant_cnt got=%h want=00", grant_cnt);
        end
`endif
        iREN = '0;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_single_fetch;
        exp_t e;
        int c, n;
        logic [AW-1:0] d;
        set_addr(0, 32'h100);
        iREN          = 4'b0001;
        ram_iwait     = 1'b1;
        use_model     = 1'b0;
        ram_iload_drv = 32'hDEADBEEF;
        push_exp(0, 32'hDEADBEEF);
        @(negedge CLK);
        checks++;
        if (ram_iREN !== 1'b0) begin
            failures++;
            $display("FAIL single_cycle0_ram_iREN got=%b want=0", ram_iREN);
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++;
        if (ram_iREN !== 1'b1 || ram_iaddr !== 32'h100) begin
            failures++;
            $display("FAIL single_cycle1_req got ren=%b addr=%h want ren=1 addr=00000100", ram_iREN, ram_iaddr);
        end
        checks++;
        if (iwait !== 4'b0001) begin
            failures++;
            $display("FAIL single_stall_iwait got=%b want=0001", iwait);
        end
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        ram_iwait = 1'b0;
        wait_cpl(4, c, d, n);
        pop_exp(e);
        checks++;
        if (c !== e.core || d !== e.data || n !== 1) begin
            failures++;
            $display("FAIL single_cpl got core=%0d data=%h cyc=%0d want core=%0d data=%h cyc=1", c, d, n, e.core, e.data);
        end
        checks++;
        if (iwait !== 4'b0000) begin
            failures++;
            $display("FAIL single_cpl_iwait got=%b want=0000", iwait);
        end
        @(posedge CLK); #1;
        ram_iwait = 1'b1;
        iREN      = '0;
        @(negedge CLK);
        checks++;
        if (ram_iREN !== 1'b0) begin
            failures++;
            $display("FAIL single_back_idle got=%b want=0", ram_iREN);
        end
    endtask

    task automatic test_round_robin;
        exp_t e;
        int c, n;
        logic [AW-1:0] d;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        for (int i = 0; i < NC; i++) set_addr(i, 32'h1000 + 32'(i) * 32'h10);
        iREN      = 4'b1111;
        ram_iwait = 1'b0;
        use_model = 1'b1;
        push_exp(0, mem_f(32'h1000));
        push_exp(1, mem_f(32'h1010));
        push_exp(2, mem_f(32'h1020));
        push_exp(3, mem_f(32'h1030));
        push_exp(0, mem_f(32'h1000));
        for (int k = 0; k < 5; k++) begin
            wait_cpl(8, c, d, n);
            pop_exp(e);
            checks++;
            if (c !== e.core || d !== e.data || n !== 2) begin
                failures++;
                $display("FAIL rr_cpl%0d got core=%0d data=%h cyc=%0d want core=%0d data=%h cyc=2", k, c, d, n, e.core, e.data);
            end
        end
        @(posedge CLK); #1;
        iREN      = '0;
        ram_iwait = 1'b1;
`ifdef IBUS_ARB_STATS_EN
        @(negedge CLK);
        checks++;
        if (grant_cnt !== 8'b01_01_01_10) begin
            failures++;
            $display("FAIL rr_grant_cnt got=%b want=01010110", grant_cnt);
        end
`endif
    endtask

    task automatic test_abort_addr;
        exp_t e;
        int c, n;
        bit ok;
        logic [AW-1:0] d;
        set_addr(1, 32'h200);
        iREN      = 4'b0010;
        ram_iwait = 1'b1;
        use_model = 1'b1;
        wait_busy(6, ok);
        checks++;
        if (!ok || ram_iaddr !== 32'h200) begin
            failures++;
            $display("FAIL abort_addr_grant got busy=%0d addr=%h want busy=1 addr=00000200", ok, ram_iaddr);
        end
        @(posedge CLK); #1;
        set_addr(1, 32'h204);
        set_addr(0, 32'h300);
        iREN = 4'b0011;
        @(negedge CLK);
        checks++;
        if (iwait !== 4'b0011 || ram_iaddr !== 32'h200) begin
            failures++;
            $display("FAIL abort_addr_cycle got iwait=%b addr=%h want iwait=0011 addr=00000200", iwait, ram_iaddr);
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++;
        if (ram_iREN !== 1'b0) begin
            failures++;
            $display("FAIL abort_addr_idle got ren=%b want 0", ram_iREN);
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++;
        if (ram_iREN !== 1'b1 || ram_iaddr !== 32'h204) begin
            failures++;
            $display("FAIL abort_addr_regrant got ren=%b addr=%h want ren=1 addr=00000204", ram_iREN, ram_iaddr);
        end
        push_exp(1, mem_f(32'h204));
        @(posedge CLK); #1;
        ram_iwait = 1'b0;
        wait_cpl(4, c, d, n);
        pop_exp(e);
        checks++;
        if (c !== e.core || d !== e.data) begin
            failures++;
            $display("FAIL abort_addr_cpl1 got core=%0d data=%h want core=%0d data=%h", c, d, e.core, e.data);
        end
        @(posedge CLK); #1;
        iREN = 4'b0001;
        push_exp(0, mem_f(32'h300));
        wait_cpl(6, c, d, n);
        pop_exp(e);
        checks++;
        if (c !== e.core || d !== e.data) begin
            failures++;
            $display("FAIL abort_addr_cpl0 got core=%0d data=%h want core=%0d data=%h", c, d, e.core, e.data);
        end
        @(posedge CLK); #1;
        iREN      = '0;
        ram_iwait = 1'b1;
    endtask

    task automatic test_abort_drop;
        exp_t e;
        int c, n;
        bit ok;
        logic [AW-1:0] d;
        set_addr(3, 32'h3F0);
        iREN      = 4'b1000;
        ram_iwait = 1'b0;
        push_exp(3, mem_f(32'h3F0));
        wait_cpl(6, c, d, n);
        pop_exp(e);
        checks++;
        if (c !== e.core || d !== e.data) begin
            failures++;
            $display("FAIL drop_wrap_cpl got core=%0d data=%h want core=%0d data=%h", c, d, e.core, e.data);
        end
        @(posedge CLK); #1;
        iREN      = '0;
        ram_iwait = 1'b1;
        set_addr(0, 32'h400);
        iREN = 4'b0001;
        wait_busy(6, ok);
        @(posedge CLK); #1;
        iREN      = '0;
        ram_iwait = 1'b0;
        @(negedge CLK);
        checks++;
        if (!ok || ram_iREN !== 1'b1) begin
            failures++;
            $display("FAIL drop_busy got busy=%0d ren=%b want busy=1 ren=1", ok, ram_iREN);
        end
        @(posedge CLK); #1;
        set_addr(1, 32'h410);
        iREN      = 4'b0011;
        ram_iwait = 1'b1;
        wait_busy(6, ok);
        checks++;
        if (!ok || ram_iaddr !== 32'h400) begin
            failures++;
            $display("FAIL drop_ptr_kept got busy=%0d addr=%h want busy=1 addr=00000400", ok, ram_iaddr);
        end
`ifdef IBUS_ARB_STATS_EN
        checks++;
        if (grant_cnt !== 8'b10_01_10_11) begin
            failures++;
            $display("FAIL drop_grant_cnt got=%b want=10011011", grant_cnt);
        end
`endif
        push_exp(0, mem_f(32'h400));
        push_exp(1, mem_f(32'h410));
        @(posedge CLK); #1;
        ram_iwait = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wait_cpl(6, c, d, n);
            pop_exp(e);
            checks++;
            if (c !== e.core || d !== e.data) begin
                failures++;
                $display("FAIL drop_cpl%0d got core=%0d data=%h want core=%0d data=%h", k, c, d, e.core, e.data);
            end
        end
        @(posedge CLK); #1;
        iREN      = 4'b0001;
        ram_iwait = 1'b1;
    endtask

    task automatic test_reset_mid_busy;
        exp_t e;
        int c, n;
        bit ok;
        logic [AW-1:0] d;
        wait_busy(6, ok);
        checks++;
        if (!ok || ram_iaddr !== 32'h400) begin
            failures++;
            $display("FAIL rst_busy_setup got busy=%0d addr=%h want busy=1 addr=00000400", ok, ram_iaddr);
        end
        @(posedge CLK); #3;
        RST = 1'b1;
        #1;
        checks++;
        if (ram_iREN !== 1'b0 || ram_iaddr !== 32'h0 || iwait !== 4'b0001) begin
            failures++;
            $display("FAIL rst_async got ren=%b addr=%h iwait=%b want ren=0 addr=00000000 iwait=0001", ram_iREN, ram_iaddr, iwait);
        end
`ifdef IBUS_ARB_STATS_EN
        checks++;
        if (grant_cnt !== 8'h00) begin
            failures++;
            $display("FAIL rst_grant_cnt got=%h want=00", grant_cnt);
        end
`endif
        @(posedge CLK); #1;
        RST = 1'b0;
        set_addr(1, 32'h500);
        set_addr(2, 32'h600);
        iREN = 4'b0110;
        wait_busy(6, ok);
        checks++;
        if (!ok || ram_iaddr !== 32'h500) begin
            failures++;
            $display("FAIL rst_first_grant got busy=%0d addr=%h want busy=1 addr=00000500", ok, ram_iaddr);
        end
        push_exp(1, mem_f(32'h500));
        @(posedge CLK); #1;
        ram_iwait = 1'b0;
        wait_cpl(4, c, d, n);
        pop_exp(e);
        checks++;
        if (c !== e.core || d !== e.data) begin
            failures++;
            $display("FAIL rst_cpl got core=%0d data=%h want core=%0d data=%h", c, d, e.core, e.data);
        end
        @(posedge CLK); #1;
        iREN      = '0;
        ram_iwait = 1'b1;
    endtask

`ifdef IBUS_ARB_STATS_EN
    task automatic test_stats_saturation;
        exp_t e;
        int c, n;
        logic [AW-1:0] d;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        set_addr(0, 32'h700);
        iREN      = 4'b0001;
        ram_iwait = 1'b0;
        for (int k = 0; k < 5; k++) push_exp(0, mem_f(32'h700));
        for (int k = 0; k < 5; k++) begin
            wait_cpl(6, c, d, n);
            pop_exp(e);
            checks++;
            if (c !== e.core || d !== e.data) begin
                failures++;
                $display("FAIL sat_cpl%0d got core=%0d data=%h want core=%0d data=%h", k, c, d, e.core, e.data);
            end
        end
        @(posedge CLK); #1;
        iREN      = '0;
        ram_iwait = 1'b1;
        @(negedge CLK);
        checks++;
        if (grant_cnt !== 8'b00_00_00_11) begin
            failures++;
            $display("FAIL sat_grant_cnt got=%b want=00000011", grant_cnt);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        RST           = 1'b1;
        iREN          = '0;
        iaddr         = '0;
        ram_iwait     = 1'b1;
        ram_iload_drv = '0;
        use_model     = 1'b0;
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_abort_addr();
        test_abort_drop();
        test_reset_mid_busy();
`ifdef IBUS_ARB_STATS_EN
        test_stats_saturation();
`endif
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i_bus_arbiter_n.md
Name: i_bus_arbiter_n

Overview:
- Parametrised successor to the dual-core instruction-bus control block: arbitrates NCORES instruction-fetch requesters onto one memory instruction port.
- Uses registered round-robin grant with a transaction lock, and supports abort on request withdrawal or address change.
- Sits between the per-core icaches and the memory controller's instruction port.

Parameters:
NCORES, 2, number of requesting cores (2..8)
AW, 32, address/data word width (word_t)
CNTW, 16, width of per-core grant counters (used only with IBUS_ARB_STATS_EN)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-high reset
iREN  input  NCORES  per-core fetch request
iaddr  input  NCORES*AW  per-core fetch address, core i at bits [i*AW +: AW]
iwait  output  NCORES  per-core stall; low means iload valid this cycle for a requesting core
iload  output  NCORES*AW  per-core fetch data
ram_iREN  output  1  memory instruction read enable
ram_iaddr  output  AW  memory instruction address
ram_iload  input  AW  memory instruction data
ram_iwait  input  1  memory busy; low in BUSY means data valid
grant_cnt  output  NCORES*CNTW  per-core completed-fetch counters (only with IBUS_ARB_STATS_EN)

Behaviour:
- Reset (async, RST=1): state=IDLE, ptr=0, gnt=0, addr_q=0, grant_cnt=0.
- While in reset: ram_iREN=0, ram_iaddr=0, iwait[i]=iREN[i].
- States: IDLE, BUSY.
- IDLE:
  - ram_iREN=0, ram_iaddr=addr_q.
  - If any iREN: gnt <= first requesting index searching ptr, ptr+1, ..., wrapping mod NCORES; addr_q <= iaddr[gnt]; next=BUSY.
  - Else stay in IDLE.
- BUSY:
  - ram_iREN=1, ram_iaddr=addr_q (latched, stable for the whole transaction).
  - Abort: if iREN[gnt]==0 or iaddr[gnt]!=addr_q, go to IDLE. No completion, ptr unchanged. Abort has priority over completion in the same cycle.
  - Completion: else if ram_iwait==0, complete. iwait[gnt]=0 this cycle, ptr <= (gnt+1) mod NCORES, next=IDLE.
  - Else hold in BUSY.
- iwait[i] = iREN[i] & ~(completing & gnt==i). Combinational. Never low for a non-requesting core's benefit; cores ignore it when iREN=0.
- iload[i] = ram_iload for all i (broadcast, combinational). Valid only in the completion cycle for gnt.
- Latency: request seen in cycle 0, ram_iREN in cycle 1, earliest completion in cycle 1 (ram_iwait low). Minimum 2 cycles per fetch; one IDLE bubble between back-to-back grants.
- Fairness: a continuously requesting core is served within NCORES grants.
- Simultaneous completion plus new requests: the new grant is decided in the following IDLE cycle using the updated ptr.
- ptr wrap: gnt=NCORES-1 gives ptr=0.
- Reset mid-BUSY: immediate return to IDLE and ram_iREN=0. Memory controller tolerates a dropped request.

Optional Feature:
IBUS_ARB_STATS_EN
- Defined: adds port grant_cnt. Counter i increments by 1 on each completion for core i, saturates at all-ones, clears on reset. Aborts are not counted.
- Undefined: port and counters absent; behaviour otherwise identical.

Test Plan:
- NCORES=2, only core0 requests addr 0x100, ram_iwait low after 2 cycles, ram_iload=0xDEADBEEF:
  - ram_iREN=1 with ram_iaddr=0x100 from cycle 1.
  - iwait[0]=0 and iload[0]=0xDEADBEEF in the completion cycle.
  - iwait[1] stays 0 (no request).
- NCORES=4, all cores request continuously, ram_iwait=0 always: grant order 0,1,2,3,0; one completion every 2 cycles; grant_cnt reaches 1 per core after 4 completions.
- Core1 granted at 0x200, then changes iaddr to 0x204 during BUSY with ram_iwait=1:
  - Abort to IDLE, no iwait low.
  - Re-grant with ram_iaddr=0x204; ptr still selects core1 first.
- Granted core0 drops iREN in the same cycle ram_iwait falls: abort wins, no completion, ptr unchanged.
- RST asserted mid-BUSY with ram_iwait=1: ram_iREN=0 asynchronously; after release the first grant goes to the lowest requesting index (ptr=0).
- CNTW=2 with IBUS_ARB_STATS_EN: 5 completions for core0 give grant_cnt[0]=3 (saturated).
